// File: rtl/reg_bank_16x32.sv
// Operand register bank: NUM_REGS x DATA_W registers, two registered read ports (n1/n2), one write port.
// Optional write-to-read bypass enabled by defining REGBANK_FWD_EN.
module reg_bank_16x32 #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              stall,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] n1,
  output logic [DATA_W-1:0] n2,
  output logic              rd_valid
);

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] n1_r;
  logic [DATA_W-1:0] n2_r;
  logic              rd_valid_r;
  logic              wr_ok_s;
  logic [DATA_W-1:0] rs_val_s;
  logic [DATA_W-1:0] rt_val_s;

  // One extra bit so NUM_REGS == 2**ADDR_W does not wrap to zero.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));
  endfunction

  // Reads of R0 or unmapped addresses return zero; optional bypass from the write port.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic              wr_ok,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] regs [NUM_REGS]
  );
    logic [DATA_W-1:0] val;
    val = {DATA_W{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      if (addr == ADDR_W'(i)) begin
        val = regs[i];
      end else begin
        val = val;
      end
    end
`ifdef REGBANK_FWD_EN
    if (wr_ok && (waddr == addr)) begin
      val = wdata;
    end else begin
      val = val;
    end
`else
    if (wr_ok && (waddr == addr)) begin
      val = val;
    end else begin
      val = val;
    end
`endif
    return val;
  endfunction

  // Write qualification: R0 and unmapped addresses never take a write.
  always_comb begin
    wr_ok_s = 1'b0;
    if (wr_en && (wr_addr != {ADDR_W{1'b0}}) && addr_in_range(wr_addr)) begin
      wr_ok_s = 1'b1;
    end else begin
      wr_ok_s = 1'b0;
    end
  end

  // Read-port operand selection.
  always_comb begin
    rs_val_s = read_port(rs_addr, wr_ok_s, wr_addr, wr_data, regs_r);
    rt_val_s = read_port(rt_addr, wr_ok_s, wr_addr, wr_data, regs_r);
  end

  // Register storage; reset clears every entry and discards a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

  // Operand output registers; stall freezes all three and drops the read request.
  always_ff @(posedge clk) begin
    if (rst) begin
      n1_r       <= {DATA_W{1'b0}};
      n2_r       <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else if (!stall) begin
      if (rd_en) begin
        n1_r       <= rs_val_s;
        n2_r       <= rt_val_s;
        rd_valid_r <= 1'b1;
      end else begin
        rd_valid_r <= 1'b0;
      end
    end
  end

  assign n1       = n1_r;
  assign n2       = n2_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: tb/tb_reg_bank_16x32.sv
// Directed table-driven bench for reg_bank_16x32; expectations follow REGBANK_FWD_EN if defined.
module tb_reg_bank_16x32;

`ifdef REGBANK_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic [3:0]  rs_addr;
  logic [3:0]  rt_addr;
  logic        stall;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] n1;
  logic [31:0] n2;
  logic        rd_valid;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic        rst;
    logic        rd_en;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic        stall;
    logic        wr_en;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ev;
  } vec_t;

  vec_t vecs[$];

  reg_bank_16x32 dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .stall(stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .n1(n1), .n2(n2), .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic re, input logic [3:0] rs, input logic [3:0] rt,
                     input logic st, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [31:0] e1, input logic [31:0] e2, input logic ev);
    vec_t v;
    v.rst = r; v.rd_en = re; v.rs = rs; v.rt = rt; v.stall = st;
    v.wr_en = we; v.wa = wa; v.wd = wd; v.e1 = e1; v.e2 = e2; v.ev = ev;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; rd_en = v.rd_en; rs_addr = v.rs; rt_addr = v.rt; stall = v.stall;
    wr_en = v.wr_en; wr_addr = v.wa; wr_data = v.wd;
  endtask

  logic [31:0] model [16];

  initial begin
    vec_t v;
    rst = 1'b0; rd_en = 1'b0; rs_addr = 4'd0; rt_addr = 4'd0; stall = 1'b0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 32'd0;

    //   rst   rd    rs     rt     stall we    wa     wd              e1              e2              ev
    add(1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  32'h0,          32'h0,          32'h0,          1'b0); // 0
    add(1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd1,  32'h11111111,   32'h0,          32'h0,          1'b0); // 1
    add(1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd15, 32'hFFFF0000,   32'h0,          32'h0,          1'b0); // 2
    add(1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  32'h0,          32'h0,          32'h0,          1'b0); // 3
    add(1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  32'h0,          32'h0,          32'h0,          1'b0); // 4
    add(1'b0, 1'b1, 4'd1,  4'd15, 1'b0, 1'b0, 4'd0,  32'h0,          32'h0,          32'h0,          1'b1); // 5 regs cleared
    add(1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd3,  32'hDEADBEEF,   32'h0,          32'h0,          1'b0); // 6
    add(1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd4,  32'h12345678,   32'h0,          32'h0,          1'b0); // 7
    add(1'b0, 1'b1, 4'd3,  4'd4,  1'b0, 1'b0, 4'd0,  32'h0,          32'hDEADBEEF,   32'h12345678,   1'b1); // 8
    add(1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  32'h0,          32'hDEADBEEF,   32'h12345678,   1'b0); // 9 hold
    add(1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd0,  32'hFFFFFFFF,   32'hDEADBEEF,   32'h12345678,   1'b0); // 10 R0 write
    add(1'b0, 1'b1, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  32'h0,          32'h0,          32'h0,          1'b1); // 11
    add(1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b1, 4'd5,  32'h00000001,   32'h0,          32'h0,          1'b0); // 12
    add(1'b0, 1'b1, 4'd5,  4'd5,  1'b0, 1'b1, 4'd5,  32'hA5A5A5A5,
        FWD ? 32'hA5A5A5A5 : 32'h00000001, FWD ? 32'hA5A5A5A5 : 32'h00000001, 1'b1);                       // 13
    add(1'b0, 1'b1, 4'd5,  4'd5,  1'b0, 1'b0, 4'd0,  32'h0,          32'hA5A5A5A5,   32'hA5A5A5A5,   1'b1); // 14
    add(1'b0, 1'b1, 4'd3,  4'd4,  1'b0, 1'b0, 4'd0,  32'h0,          32'hDEADBEEF,   32'h12345678,   1'b1); // 15
    add(1'b0, 1'b1, 4'd6,  4'd1,  1'b1, 1'b1, 4'd6,  32'h00000077,   32'hDEADBEEF,   32'h12345678,   1'b1); // 16 stall
    add(1'b0, 1'b1, 4'd6,  4'd6,  1'b1, 1'b0, 4'd0,  32'h0,          32'hDEADBEEF,   32'h12345678,   1'b1); // 17
    add(1'b0, 1'b1, 4'd6,  4'd6,  1'b1, 1'b0, 4'd0,  32'h0,          32'hDEADBEEF,   32'h12345678,   1'b1); // 18
    add(1'b0, 1'b1, 4'd6,  4'd3,  1'b0, 1'b0, 4'd0,  32'h0,          32'h00000077,   32'hDEADBEEF,   1'b1); // 19
    add(1'b1, 1'b1, 4'd7,  4'd7,  1'b0, 1'b1, 4'd7,  32'h00000055,   32'h0,          32'h0,          1'b0); // 20 rst wins
    add(1'b0, 1'b1, 4'd7,  4'd3,  1'b0, 1'b0, 4'd0,  32'h0,          32'h0,          32'h0,          1'b1); // 21
    add(1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  32'h0,          32'h0,          32'h0,          1'b0); // 22
    add(1'b0, 1'b1, 4'd3,  4'd3,  1'b1, 1'b0, 4'd0,  32'h0,          32'h0,          32'h0,          1'b0); // 23 stall, no queue
    add(1'b0, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  32'h0,          32'h0,          32'h0,          1'b0); // 24
    add(1'b0, 1'b1, 4'd15, 4'd0,  1'b0, 1'b1, 4'd15, 32'hCAFEF00D,
        FWD ? 32'hCAFEF00D : 32'h0, 32'h0, 1'b1);                                                           // 25
    add(1'b0, 1'b1, 4'd15, 4'd15, 1'b0, 1'b0, 4'd0,  32'h0,          32'hCAFEF00D,   32'hCAFEF00D,   1'b1); // 26
    add(1'b0, 1'b1, 4'd0,  4'd15, 1'b0, 1'b1, 4'd0,  32'h12345678,   32'h0,          32'hCAFEF00D,   1'b1); // 27 no R0 bypass

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check32($sformatf("v%0d n1", i), n1, vecs[i].e1);
      check32($sformatf("v%0d n2", i), n2, vecs[i].e2);
      check1($sformatf("v%0d rd_valid", i), rd_valid, vecs[i].ev);
      if (i == 8) begin
        check32("xor_3_4", n1 ^ n2, 32'hCC99E897);
      end
    end

    // Fill every register, then back-to-back reads against a small model.
    for (int r = 0; r < 16; r++) model[r] = 32'h0;
    model[15] = 32'hCAFEF00D;
    for (int r = 1; r < 16; r++) begin
      @(negedge clk);
      v = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'(r), 32'h01010101 * 32'(r) ^ 32'h80000000,
            32'h0, 32'h0, 1'b0};
      drive(v);
      model[r] = 32'h01010101 * 32'(r) ^ 32'h80000000;
    end
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      v = '{1'b0, 1'b1, 4'(r), 4'(15 - r), 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 1'b0};
      drive(v);
      @(posedge clk);
      #1;
      check32($sformatf("seq rs=%0d n1", r), n1, model[r]);
      check32($sformatf("seq rt=%0d n2", 15 - r), n2, model[15 - r]);
      check1($sformatf("seq r%0d rd_valid", r), rd_valid, 1'b1);
    end

    @(negedge clk);
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    check1("seq end rd_valid", rd_valid, 1'b0);
    check32("seq end n1 hold", n1, model[15]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
